alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle ALU sequencer for the 12-bit accumulator CPU. Accepts an opcode and two 12-bit operands from the control unit, computes the result (single-cycle logic/arithmetic, iterative shifts, shift-add multiply), and presents opcode, operands and result with a one-cycle ACLOAD strobe. It sits directly upstream of flags_setter, which consumes opcode/op1/op2/AC_result/ACLOAD, and of the accumulator register, which consumes AC_result/ac_we.

## Interface
- No parameters; datapath fixed at 12 bits, opcode at 4 bits.
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- opcode_in  in  4  operation select
- a  in  12  accumulator value (first operand)
- b  in  12  second operand (memory/immediate)
- busy  out  1  high from the cycle after an accepted start until ACLOAD cycle inclusive
- ACLOAD  out  1  one-cycle strobe: result valid
- ac_we  out  1  accumulator write enable; equals ACLOAD except 0 for CMP and NOP
- opcode  out  4  captured opcode
- op1  out  12  captured a
- op2  out  12  captured b
- AC_result  out  12  result

## Operation
- Opcodes: 0000 NOP (result = a), 0001 AND, 0010 OR, 0011 XOR, 0101 NOT a, 0100 CMP (result = a − b), 0110 SHL, 0111 SHR, 1000 MUL, 1001 ADD, 1010 SUB; undefined codes behave as NOP.
- All arithmetic modulo 2^12; ADD/SUB/CMP results truncated to 12 bits; flag derivation is not this block's job.
- SHL/SHR: logical, zero fill, shift count = b[3:0] saturated at 12 (count ≥ 12 → result 0x000).
- MUL: unsigned shift-add, 12 iterations, AC_result = low 12 bits of a × b.
- States: IDLE, EXEC, SHIFT, MUL, DONE.
  - IDLE: start=1 → capture opcode_in/a/b into opcode/op1/op2, load working regs; go EXEC (logic/arith/NOP/CMP, or shift with count 0), SHIFT (count ≥ 1), MUL.
  - EXEC: compute result → DONE.
  - SHIFT: one bit per cycle, decrement counter; at counter = 0 → DONE.
  - MUL: one partial product per cycle, 12 cycles → DONE.
  - DONE: ACLOAD=1, ac_we per opcode, AC_result valid → IDLE.
- start while not IDLE: ignored, no queuing.
- opcode/op1/op2/AC_result hold their values after DONE until the next accepted start.
- Reset (any state, including mid-SHIFT/MUL): state IDLE, all outputs 0 (busy, ACLOAD, ac_we, opcode, op1, op2, AC_result), counters cleared; aborted op produces no strobe.

## Timing
- Start accepted in cycle T (IDLE). opcode/op1/op2 valid from T+1.
- EXEC-class ops: ACLOAD in cycle T+2.
- Shifts: ACLOAD in T+2+n, n = saturated count (n=0 → T+2).
- MUL: ACLOAD in T+14.
- busy high T+1 through ACLOAD cycle; low the cycle after; new start accepted in that cycle (back-to-back throughput = latency + 1).
- AC_result stable throughout the ACLOAD cycle; op1/op2/opcode unchanged while ACLOAD high, so flags_setter sees coherent inputs.
- start held high continuously: re-accepted on every return to IDLE.

## Test plan
- Reset: rst=0 for 2 cycles with start=1 → all outputs 0, busy=0, no ACLOAD.
- ADD a=0xFFF b=0x001 → AC_result 0x000, ACLOAD and ac_we one cycle at T+2; op1=0xFFF op2=0x001 opcode=1001.
- CMP a=0x005 b=0x002 → AC_result 0x003, ACLOAD=1, ac_we=0 at T+2; SUB same operands → ac_we=1.
- SHL a=0x001 b=0x005 → 0x020 at T+7; SHR a=0x800 b=0x00F → 0x000 at T+14; start pulses during busy ignored.
- MUL a=0x012 b=0x010 → 0x120 at T+14; MUL a=0xFFF b=0xFFF → 0x001.
- Reset asserted at T+6 of MUL → outputs 0 next cycle, no ACLOAD; subsequent ADD 0x7FF+0x001 → 0x800 at normal latency.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Function : multi-cycle 12-bit ALU sequencer (logic/arith, iterative shift,
//            shift-add multiply) with a one-cycle ACLOAD result strobe.
// Revision : 1.0
// ============================================================================
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  opcode_in,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic        busy,
    output logic        ACLOAD,
    output logic        ac_we,
    output logic [3:0]  opcode,
    output logic [11:0] op1,
    output logic [11:0] op2,
    output logic [11:0] AC_result
);

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_CMP = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_ADD = 4'b1001;
    localparam logic [3:0] OP_SUB = 4'b1010;

    localparam logic [3:0] MUL_STEPS = 4'd12;
    localparam logic [3:0] SHIFT_MAX = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_SHIFT = 3'd2,
        S_MUL   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q,  state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [11:0] op1_q,    op1_d;
    logic [11:0] op2_q,    op2_d;
    logic [11:0] result_q, result_d;
    logic        busy_q,   busy_d;
    logic        acload_q, acload_d;
    logic        ac_we_q,  ac_we_d;
    logic [11:0] work_q,   work_d;
    logic [11:0] acc_q,    acc_d;
    logic [11:0] mplier_q, mplier_d;
    logic [3:0]  cnt_q,    cnt_d;

    logic [3:0]  shift_sat;
    logic [11:0] exec_res;
    logic        exec_we;

    assign shift_sat = (b[3:0] > SHIFT_MAX) ? SHIFT_MAX : b[3:0];

    // Single-cycle results; SHL/SHR only land in EXEC with a zero count.
    always_comb begin
        exec_res = op1_q;
        exec_we  = 1'b0;
        case (opcode_q)
            OP_AND: begin exec_res = op1_q & op2_q; exec_we = 1'b1; end
            OP_OR:  begin exec_res = op1_q | op2_q; exec_we = 1'b1; end
            OP_XOR: begin exec_res = op1_q ^ op2_q; exec_we = 1'b1; end
            OP_NOT: begin exec_res = ~op1_q;        exec_we = 1'b1; end
            OP_CMP: begin exec_res = op1_q - op2_q; exec_we = 1'b0; end
            OP_SHL: begin exec_res = op1_q;         exec_we = 1'b1; end
            OP_SHR: begin exec_res = op1_q;         exec_we = 1'b1; end
            OP_ADD: begin exec_res = op1_q + op2_q; exec_we = 1'b1; end
            OP_SUB: begin exec_res = op1_q - op2_q; exec_we = 1'b1; end
            default: begin exec_res = op1_q;        exec_we = 1'b0; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        busy_d   = busy_q;
        acload_d = 1'b0;
        ac_we_d  = 1'b0;
        work_d   = work_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opcode_d = opcode_in;
                    op1_d    = a;
                    op2_d    = b;
                    busy_d   = 1'b1;
                    work_d   = a;
                    acc_d    = 12'h000;
                    mplier_d = b;
                    if (opcode_in == OP_MUL) begin
                        cnt_d   = MUL_STEPS;
                        state_d = S_MUL;
                    end else if ((opcode_in == OP_SHL || opcode_in == OP_SHR)
                                 && shift_sat != 4'd0) begin
                        cnt_d   = shift_sat;
                        state_d = S_SHIFT;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                result_d = exec_res;
                acload_d = 1'b1;
                ac_we_d  = exec_we;
                state_d  = S_DONE;
            end
            S_SHIFT: begin
                // The cycle that observes a zero count publishes the result.
                if (cnt_q != 4'd0) begin
                    work_d = (opcode_q == OP_SHL) ? {work_q[10:0], 1'b0}
                                                  : {1'b0, work_q[11:1]};
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    result_d = work_q;
                    acload_d = 1'b1;
                    ac_we_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_MUL: begin
                if (cnt_q != 4'd0) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + work_q;
                    end
                    work_d   = {work_q[10:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[11:1]};
                    cnt_d    = cnt_q - 4'd1;
                end else begin
                    result_d = acc_q;
                    acload_d = 1'b1;
                    ac_we_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            opcode_q <= 4'h0;
            op1_q    <= 12'h000;
            op2_q    <= 12'h000;
            result_q <= 12'h000;
            busy_q   <= 1'b0;
            acload_q <= 1'b0;
            ac_we_q  <= 1'b0;
            work_q   <= 12'h000;
            acc_q    <= 12'h000;
            mplier_q <= 12'h000;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            acload_q <= acload_d;
            ac_we_q  <= ac_we_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign ACLOAD    = acload_q;
    assign ac_we     = ac_we_q;
    assign opcode    = opcode_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign AC_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Function : self-checking bench for alu_seq (latency/result model + vectors)
// Revision : 1.0
// ============================================================================
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  opcode_in;
    logic [11:0] a;
    logic [11:0] b;
    logic        busy;
    logic        ACLOAD;
    logic        ac_we;
    logic [3:0]  opcode;
    logic [11:0] op1;
    logic [11:0] op2;
    logic [11:0] AC_result;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    alu_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode_in (opcode_in),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .ACLOAD    (ACLOAD),
        .ac_we     (ac_we),
        .opcode    (opcode),
        .op1       (op1),
        .op2       (op2),
        .AC_result (AC_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int sat_count(input logic [11:0] y);
        return (y[3:0] > 4'd12) ? 12 : int'(y[3:0]);
    endfunction

    function automatic logic [11:0] ref_result(input logic [3:0] op,
                                               input logic [11:0] x,
                                               input logic [11:0] y);
        logic [23:0] prod;
        logic [11:0] r;
        prod = x * y;
        case (op)
            4'h1: r = x & y;
            4'h2: r = x | y;
            4'h3: r = x ^ y;
            4'h4: r = x - y;
            4'h5: r = ~x;
            4'h6: r = x << sat_count(y);
            4'h7: r = x >> sat_count(y);
            4'h8: r = prod[11:0];
            4'h9: r = x + y;
            4'hA: r = x - y;
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [11:0] y);
        if (op == 4'h6 || op == 4'h7) return 2 + sat_count(y);
        if (op == 4'h8) return 14;
        return 2;
    endfunction

    function automatic bit ref_we(input logic [3:0] op);
        return (op >= 4'h1 && op <= 4'hA && op != 4'h4);
    endfunction

    // Transaction-level model: accept time, strobe time, captured values.
    bit          m_act  = 1'b0;
    int          m_t    = 0;
    int          m_ack  = 0;
    bit          m_we   = 1'b0;
    logic [3:0]  m_opc  = 4'h0;
    logic [11:0] m_op1  = 12'h0;
    logic [11:0] m_op2  = 12'h0;
    logic [11:0] m_res  = 12'h0;
    logic [11:0] m_last = 12'h0;

    always @(posedge clk) begin
        if (!rst) begin
            m_act  = 1'b0;
            m_opc  = 4'h0;
            m_op1  = 12'h0;
            m_op2  = 12'h0;
            m_last = 12'h0;
        end else begin
            if (m_act && cyc == m_ack) m_last = m_res;
            if ((!m_act || cyc > m_ack) && start) begin
                m_act = 1'b1;
                m_t   = cyc;
                m_ack = cyc + ref_latency(opcode_in, b);
                m_res = ref_result(opcode_in, a, b);
                m_we  = ref_we(opcode_in);
                m_opc = opcode_in;
                m_op1 = a;
                m_op2 = b;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        bit e_busy, e_ld;
        if (cyc > 0) begin
            e_busy = m_act && cyc > m_t && cyc <= m_ack;
            e_ld   = m_act && cyc == m_ack;
            chk("model busy",   {11'h0, busy},   {11'h0, e_busy});
            chk("model ACLOAD", {11'h0, ACLOAD}, {11'h0, e_ld});
            chk("model ac_we",  {11'h0, ac_we},  {11'h0, e_ld && m_we});
            chk("model opcode", {8'h0, opcode},  {8'h0, m_opc});
            chk("model op1",    op1, m_op1);
            chk("model op2",    op2, m_op2);
            if (e_ld)
                chk("model AC_result", AC_result, m_res);
            else if (!e_busy)
                chk("model AC_result held", AC_result, m_last);
        end
    end

    // Called just after a posedge with the DUT idle; returns just after the
    // posedge following the strobe, so consecutive calls run back-to-back.
    task automatic do_op(input string nm, input logic [3:0] op,
                         input logic [11:0] x, input logic [11:0] y,
                         input logic [11:0] exp_res, input int exp_lat,
                         input bit exp_we, input bit noise);
        int  t0;
        bit  seen;
        seen      = 1'b0;
        start     = 1'b1;
        opcode_in = op;
        a         = x;
        b         = y;
        t0        = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ACLOAD) begin
                seen  = 1'b1;
                start = 1'b0;
            end else if (noise) begin
                start     = 1'($urandom_range(0, 1));
                opcode_in = 4'($urandom_range(0, 15));
                a         = 12'($urandom_range(0, 4095));
                b         = 12'($urandom_range(0, 4095));
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL %s: ACLOAD timeout, got none expected one", nm);
        end else begin
            chk({nm, " latency"}, 12'(cyc - t0), 12'(exp_lat));
            chk({nm, " result"},  AC_result, exp_res);
            chk({nm, " ac_we"},   {11'h0, ac_we}, {11'h0, exp_we});
            chk({nm, " opcode"},  {8'h0, opcode}, {8'h0, op});
            chk({nm, " op1"},     op1, x);
            chk({nm, " op2"},     op2, y);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ld;
        rst       = 1'b0;
        start     = 1'b1;
        opcode_in = 4'h9;
        a         = 12'h001;
        b         = 12'h001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy",      {11'h0, busy},   12'h000);
        chk("reset ACLOAD",    {11'h0, ACLOAD}, 12'h000);
        chk("reset ac_we",     {11'h0, ac_we},  12'h000);
        chk("reset opcode",    {8'h0, opcode},  12'h000);
        chk("reset op1",       op1,             12'h000);
        chk("reset op2",       op2,             12'h000);
        chk("reset AC_result", AC_result,       12'h000);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;

        do_op("ADD",     4'h9, 12'hFFF, 12'h001, 12'h000, 2,  1'b1, 1'b0);
        do_op("CMP",     4'h4, 12'h005, 12'h002, 12'h003, 2,  1'b0, 1'b0);
        do_op("SUB",     4'hA, 12'h005, 12'h002, 12'h003, 2,  1'b1, 1'b0);
        do_op("AND",     4'h1, 12'h0F0, 12'h3C3, 12'h0C0, 2,  1'b1, 1'b0);
        do_op("OR",      4'h2, 12'h0F0, 12'h30C, 12'h3FC, 2,  1'b1, 1'b0);
        do_op("XOR",     4'h3, 12'hFFF, 12'h0A5, 12'hF5A, 2,  1'b1, 1'b0);
        do_op("NOT",     4'h5, 12'h0A5, 12'h123, 12'hF5A, 2,  1'b1, 1'b0);
        do_op("NOP",     4'h0, 12'h123, 12'h456, 12'h123, 2,  1'b0, 1'b0);
        do_op("UNDEF",   4'hF, 12'h456, 12'h001, 12'h456, 2,  1'b0, 1'b0);
        do_op("SHL5",    4'h6, 12'h001, 12'h005, 12'h020, 7,  1'b1, 1'b1);
        do_op("SHR15",   4'h7, 12'h800, 12'h00F, 12'h000, 14, 1'b1, 1'b1);
        do_op("SHR3",    4'h7, 12'h800, 12'h003, 12'h100, 5,  1'b1, 1'b0);
        do_op("SHL0",    4'h6, 12'h0AB, 12'h000, 12'h0AB, 2,  1'b1, 1'b0);
        do_op("SHL12",   4'h6, 12'h001, 12'h00C, 12'h000, 14, 1'b1, 1'b0);
        do_op("MUL",     4'h8, 12'h012, 12'h010, 12'h120, 14, 1'b1, 1'b0);
        do_op("MULMAX",  4'h8, 12'hFFF, 12'hFFF, 12'h001, 14, 1'b1, 1'b1);
        do_op("MULZERO", 4'h8, 12'h000, 12'hABC, 12'h000, 14, 1'b1, 1'b0);

        // start held high: accepted in T, T+3, T+6 -> strobes at T+2, T+5, T+8
        start     = 1'b1;
        opcode_in = 4'h9;
        a         = 12'h001;
        b         = 12'h002;
        n_ld      = 0;
        repeat (9) begin
            @(negedge clk);
            n_ld += int'(ACLOAD);
        end
        start = 1'b0;
        chk("held start strobes", 12'(n_ld), 12'd3);
        @(posedge clk); #1;

        // reset in cycle T+6 of a MUL aborts it without a strobe
        start     = 1'b1;
        opcode_in = 4'h8;
        a         = 12'h123;
        b         = 12'h456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy",      {11'h0, busy}, 12'h000);
        chk("abort op1",       op1,           12'h000);
        chk("abort AC_result", AC_result,     12'h000);
        n_ld = 0;
        repeat (20) begin
            @(negedge clk);
            n_ld += int'(ACLOAD);
        end
        chk("abort no strobe", 12'(n_ld), 12'd0);
        @(posedge clk); #1;
        do_op("ADD after abort", 4'h9, 12'h7FF, 12'h001, 12'h800, 2, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
